// File: rtl/psram_qspi_responder.sv
// QSPI/QPI PSRAM device model backed by an on-chip byte array, oversampled on clk.
// Optional QPI command mode (0x35 / 0xF5) is built when PSRAM_RESP_QPI_EN is defined.
module psram_qspi_responder #(
    parameter int MEM_DEPTH   = 1024,
    parameter int ADDR_WIDTH  = 24,
    parameter int WAIT_CYCLES = 6
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sck,
    input  logic                         ce_n,
    input  logic [3:0]                   sio_i,
    output logic [3:0]                   sio_o,
    output logic [3:0]                   sio_oe,
    output logic                         qpi_mode,
    output logic                         busy,
    input  logic                         bd_en,
    input  logic                         bd_we,
    input  logic [$clog2(MEM_DEPTH)-1:0] bd_addr,
    input  logic [7:0]                   bd_wdata,
    output logic [7:0]                   bd_rdata
);
    localparam int IDX_W = $clog2(MEM_DEPTH);
    localparam int CNT_W = 8;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CMD    = 3'd1;
    localparam logic [2:0] S_ADDR   = 3'd2;
    localparam logic [2:0] S_WAIT   = 3'd3;
    localparam logic [2:0] S_RDATA  = 3'd4;
    localparam logic [2:0] S_WDATA  = 3'd5;
    localparam logic [2:0] S_IGNORE = 3'd6;

    logic [7:0]       r_mem [MEM_DEPTH];
    logic             r_sck_s1, r_sck_s2, r_sck_d;
    logic             r_ce_s1, r_ce_s2, r_ce_d;
    logic [3:0]       r_sio_s1, r_sio_s2;
    logic             r_busy;
    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [6:0]       r_cmd;
    logic [6:0]       r_wsh;
    logic [7:0]       r_wbuf;
    logic             r_wr_pend;
    logic [7:0]       r_rbyte;
    logic             r_fetch;
    logic [IDX_W-1:0] r_idx;
    logic             r_rd, r_quad, r_wait;
    logic [3:0]       r_sio_o, r_sio_oe;
    logic [7:0]       r_bd_rdata;

    logic             w_qpi;
    logic             w_sck_rise, w_sck_fall, w_ce_fall, w_ce_rise;
    logic [7:0]       w_cmd_full, w_wbyte;
    logic             w_cmd_last, w_addr_last, w_byte_last;
    logic [IDX_W-1:0] w_idx_next;

    // Synchronizers are deliberately not reset: after rst the responder must
    // see a genuine ce_n fall before it re-arms.
    always_ff @(posedge clk) begin
        r_sck_s1 <= sck;   r_sck_s2 <= r_sck_s1; r_sck_d <= r_sck_s2;
        r_ce_s1  <= ce_n;  r_ce_s2  <= r_ce_s1;  r_ce_d  <= r_ce_s2;
        r_sio_s1 <= sio_i; r_sio_s2 <= r_sio_s1;
    end

    assign w_sck_rise = r_sck_s2 & ~r_sck_d;
    assign w_sck_fall = ~r_sck_s2 & r_sck_d;
    assign w_ce_fall  = ~r_ce_s2 & r_ce_d;
    assign w_ce_rise  = r_ce_s2 & ~r_ce_d;

    assign w_cmd_full  = w_qpi ? {r_cmd[3:0], r_sio_s2} : {r_cmd, r_sio_s2[0]};
    assign w_cmd_last  = w_qpi ? (r_cnt == CNT_W'(1)) : (r_cnt == CNT_W'(7));
    assign w_idx_next  = r_quad ? {r_idx[IDX_W-5:0], r_sio_s2} : {r_idx[IDX_W-2:0], r_sio_s2[0]};
    assign w_addr_last = r_quad ? (r_cnt == CNT_W'(ADDR_WIDTH/4 - 1)) : (r_cnt == CNT_W'(ADDR_WIDTH - 1));
    assign w_wbyte     = r_quad ? {r_wsh[3:0], r_sio_s2} : {r_wsh, r_sio_s2[0]};
    assign w_byte_last = r_quad ? (r_cnt == CNT_W'(1)) : (r_cnt == CNT_W'(7));

`ifdef PSRAM_RESP_QPI_EN
    logic r_qpi;
    always_ff @(posedge clk) begin
        if (rst)
            r_qpi <= 1'b0;
        else if (r_state == S_CMD && w_sck_rise && !w_ce_rise && w_cmd_last) begin
            if (w_cmd_full == 8'h35)
                r_qpi <= 1'b1;
            else if (w_cmd_full == 8'hF5 && r_qpi)
                r_qpi <= 1'b0;
        end
    end
    assign w_qpi = r_qpi;
`else
    assign w_qpi = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy    <= 1'b0;
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_cmd     <= '0;
            r_wsh     <= '0;
            r_wbuf    <= '0;
            r_wr_pend <= 1'b0;
            r_rbyte   <= '0;
            r_fetch   <= 1'b0;
            r_idx     <= '0;
            r_rd      <= 1'b0;
            r_quad    <= 1'b0;
            r_wait    <= 1'b0;
            r_sio_o   <= '0;
            r_sio_oe  <= '0;
        end else begin
            r_busy    <= ~r_ce_s2;
            r_wr_pend <= 1'b0;
            r_fetch   <= 1'b0;
            // Prefetch / commit advance the index; they never coincide with an sck edge.
            if (r_fetch) begin
                r_rbyte <= r_mem[r_idx];
                r_idx   <= r_idx + IDX_W'(1);
            end
            if (r_wr_pend)
                r_idx <= r_idx + IDX_W'(1);

            if (w_ce_rise) begin
                r_state  <= S_IDLE;
                r_sio_oe <= '0;
            end else begin
                case (r_state)
                    S_IDLE: if (w_ce_fall) begin
                        r_state <= S_CMD;
                        r_cnt   <= '0;
                    end
                    S_CMD: if (w_sck_rise) begin
                        r_cmd <= w_cmd_full[6:0];
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_cmd_last) begin
                            r_cnt   <= '0;
                            r_state <= S_ADDR;
                            case (w_cmd_full)
                                8'h03:   begin r_rd <= 1'b1; r_quad <= w_qpi; r_wait <= 1'b0; end
                                8'h02:   begin r_rd <= 1'b0; r_quad <= w_qpi; r_wait <= 1'b0; end
                                8'hEB:   begin r_rd <= 1'b1; r_quad <= 1'b1;  r_wait <= 1'b1; end
                                8'h38:   begin r_rd <= 1'b0; r_quad <= 1'b1;  r_wait <= 1'b0; end
                                default: r_state <= S_IGNORE;
                            endcase
                        end
                    end
                    S_ADDR: if (w_sck_rise) begin
                        r_idx <= w_idx_next;
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_addr_last) begin
                            r_cnt <= '0;
                            if (!r_rd)
                                r_state <= S_WDATA;
                            else if (r_wait && WAIT_CYCLES != 0)
                                r_state <= S_WAIT;
                            else begin
                                r_state <= S_RDATA;
                                r_fetch <= 1'b1;
                            end
                        end
                    end
                    S_WAIT: if (w_sck_rise) begin
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (r_cnt == CNT_W'(WAIT_CYCLES - 1)) begin
                            r_cnt   <= '0;
                            r_state <= S_RDATA;
                            r_fetch <= 1'b1;
                        end
                    end
                    S_RDATA: if (w_sck_fall) begin
                        r_sio_oe <= r_quad ? 4'b1111 : 4'b0010;
                        if (r_quad)
                            r_sio_o <= r_cnt[0] ? r_rbyte[3:0] : r_rbyte[7:4];
                        else
                            r_sio_o <= {2'b00, r_rbyte[3'd7 - r_cnt[2:0]], 1'b0};
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_byte_last) begin
                            r_cnt   <= '0;
                            r_fetch <= 1'b1;
                        end
                    end
                    S_WDATA: if (w_sck_rise) begin
                        r_wsh <= w_wbyte[6:0];
                        r_cnt <= r_cnt + CNT_W'(1);
                        if (w_byte_last) begin
                            r_cnt     <= '0;
                            r_wbuf    <= w_wbyte;
                            r_wr_pend <= 1'b1;
                        end
                    end
                    S_IGNORE: ;
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // Serial-side commit wins over a same-cycle backdoor write.
    always_ff @(posedge clk) begin
        if (r_wr_pend)
            r_mem[r_idx] <= r_wbuf;
        else if (bd_en && bd_we)
            r_mem[bd_addr] <= bd_wdata;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_bd_rdata <= '0;
        else if (bd_en && !bd_we)
            r_bd_rdata <= r_mem[bd_addr];
    end

    assign sio_o    = r_sio_o;
    assign sio_oe   = r_sio_oe;
    assign qpi_mode = w_qpi;
    assign busy     = r_busy;
    assign bd_rdata = r_bd_rdata;
endmodule

// File: tb/tb_psram_qspi_responder.sv
// Self-checking bench for psram_qspi_responder: drives a mode-0 controller model
// and compares read data against a byte-model scoreboard.
module tb_psram_qspi_responder;
    localparam int MEM_DEPTH = 1024;
    localparam int AW        = $clog2(MEM_DEPTH);

    logic          clk = 1'b0, rst = 1'b1, sck = 1'b0, ce_n = 1'b1;
    logic [3:0]    sio_i = 4'h0;
    logic [3:0]    sio_o, sio_oe;
    logic          qpi_mode, busy;
    logic          bd_en = 1'b0, bd_we = 1'b0;
    logic [AW-1:0] bd_addr = '0;
    logic [7:0]    bd_wdata = 8'h00, bd_rdata;

    int         n_checks = 0, n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] model [MEM_DEPTH];

    always #5 clk = ~clk;

    psram_qspi_responder #(.MEM_DEPTH(MEM_DEPTH), .ADDR_WIDTH(24), .WAIT_CYCLES(6)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ce_n(ce_n), .sio_i(sio_i),
        .sio_o(sio_o), .sio_oe(sio_oe), .qpi_mode(qpi_mode), .busy(busy),
        .bd_en(bd_en), .bd_we(bd_we), .bd_addr(bd_addr), .bd_wdata(bd_wdata),
        .bd_rdata(bd_rdata)
    );

    // One sck period (8 clk); q/oe are what the controller sees at the rise.
    task automatic pulse(input logic [3:0] d, output logic [3:0] q, output logic [3:0] oe);
        sio_i = d; #40; q = sio_o; oe = sio_oe; sck = 1'b1; #40; sck = 1'b0;
    endtask

    task automatic cs_begin();
        @(negedge clk); ce_n = 1'b0; #80;
    endtask

    task automatic cs_end();
        #40; ce_n = 1'b1; sio_i = 4'h0; #200;
    endtask

    task automatic tx_ser(input logic [7:0] b);
        logic [3:0] q, oe;
        for (int i = 7; i >= 0; i--) pulse({3'b000, b[i]}, q, oe);
    endtask

    task automatic tx_quad(input logic [7:0] b);
        logic [3:0] q, oe;
        pulse(b[7:4], q, oe); pulse(b[3:0], q, oe);
    endtask

    task automatic tx_addr_ser(input logic [23:0] a);
        tx_ser(a[23:16]); tx_ser(a[15:8]); tx_ser(a[7:0]);
    endtask

    task automatic tx_addr_quad(input logic [23:0] a);
        tx_quad(a[23:16]); tx_quad(a[15:8]); tx_quad(a[7:0]);
    endtask

    task automatic rx_ser(output logic [7:0] b, output logic [3:0] oe0);
        logic [3:0] q, oe;
        for (int i = 7; i >= 0; i--) begin
            pulse(4'h0, q, oe);
            b[i] = q[1];
            if (i == 7) oe0 = oe;
        end
    endtask

    task automatic rx_quad(output logic [7:0] b, output logic [3:0] oe0);
        logic [3:0] q, oe;
        pulse(4'h0, q, oe); b[7:4] = q; oe0 = oe;
        pulse(4'h0, q, oe); b[3:0] = q;
    endtask

    task automatic dummy(input int n, output logic [3:0] last_oe);
        logic [3:0] q;
        for (int i = 0; i < n; i++) pulse(4'h0, q, last_oe);
    endtask

    task automatic bd_write(input logic [AW-1:0] a, input logic [7:0] d);
        @(negedge clk); bd_en = 1'b1; bd_we = 1'b1; bd_addr = a; bd_wdata = d;
        @(negedge clk); bd_en = 1'b0; bd_we = 1'b0;
        model[a] = d;
    endtask

    task automatic bd_read(input logic [AW-1:0] a, output logic [7:0] d);
        @(negedge clk); bd_en = 1'b1; bd_we = 1'b0; bd_addr = a;
        @(negedge clk); bd_en = 1'b0; d = bd_rdata;
    endtask

    task automatic test_reset();
        rst = 1'b1; repeat (5) @(negedge clk); rst = 1'b0; @(negedge clk);
        n_checks++; if (sio_o !== 4'h0)  begin n_fail++; $display("FAIL reset sio_o: got %h expected 0", sio_o); end
        n_checks++; if (sio_oe !== 4'h0) begin n_fail++; $display("FAIL reset sio_oe: got %h expected 0", sio_oe); end
        n_checks++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL reset qpi_mode: got %b expected 0", qpi_mode); end
        n_checks++; if (busy !== 1'b0)   begin n_fail++; $display("FAIL reset busy: got %b expected 0", busy); end
        n_checks++; if (bd_rdata !== 8'h00) begin n_fail++; $display("FAIL reset bd_rdata: got %h expected 0", bd_rdata); end
    endtask

    task automatic test_serial_read();
        logic [7:0] b, e; logic [3:0] oe;
        bd_write(10'h010, 8'h5A); bd_write(10'h011, 8'hC3);
        exp_q.push_back(model[10'h010]); exp_q.push_back(model[10'h011]);
        cs_begin(); tx_ser(8'h03); tx_addr_ser(24'h000010);
        for (int i = 0; i < 2; i++) begin
            rx_ser(b, oe); e = exp_q.pop_front();
            n_checks++; if (b !== e) begin n_fail++; $display("FAIL serial_read byte%0d: got %h expected %h", i, b, e); end
            n_checks++; if (oe !== 4'b0010) begin n_fail++; $display("FAIL serial_read oe%0d: got %b expected 0010", i, oe); end
        end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL serial_read busy: got %b expected 1", busy); end
        cs_end();
        n_checks++; if (sio_oe !== 4'h0) begin n_fail++; $display("FAIL serial_read oe_after: got %b expected 0", sio_oe); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL serial_read busy_after: got %b expected 0", busy); end
    endtask

    task automatic test_quad_write_read();
        logic [7:0] b, e; logic [3:0] q, oe;
        cs_begin(); tx_ser(8'h38); tx_addr_quad(24'h000100);
        pulse(4'h1, q, oe); pulse(4'h2, q, oe); pulse(4'h3, q, oe); pulse(4'h4, q, oe);
        cs_end();
        model[10'h100] = 8'h12; model[10'h101] = 8'h34;
        exp_q.push_back(model[10'h100]); exp_q.push_back(model[10'h101]);
        for (int i = 0; i < 2; i++) begin
            bd_read(AW'(10'h100 + i), b); e = exp_q.pop_front();
            n_checks++; if (b !== e) begin n_fail++; $display("FAIL quad_write byte%0d: got %h expected %h", i, b, e); end
        end
        exp_q.push_back(model[10'h100]); exp_q.push_back(model[10'h101]);
        cs_begin(); tx_ser(8'hEB); tx_addr_quad(24'h000100);
        dummy(6, oe);
        n_checks++; if (oe !== 4'h0) begin n_fail++; $display("FAIL quad_read wait_oe: got %b expected 0", oe); end
        for (int i = 0; i < 2; i++) begin
            rx_quad(b, oe); e = exp_q.pop_front();
            n_checks++; if (b !== e) begin n_fail++; $display("FAIL quad_read byte%0d: got %h expected %h", i, b, e); end
            n_checks++; if (oe !== 4'b1111) begin n_fail++; $display("FAIL quad_read oe%0d: got %b expected 1111", i, oe); end
        end
        cs_end();
    endtask

    task automatic test_wrap();
        logic [7:0] b, e;
        cs_begin(); tx_ser(8'h02); tx_addr_ser(24'(MEM_DEPTH - 1)); tx_ser(8'hAA); tx_ser(8'hBB); cs_end();
        model[MEM_DEPTH-1] = 8'hAA; model[0] = 8'hBB;
        exp_q.push_back(model[MEM_DEPTH-1]); exp_q.push_back(model[0]);
        bd_read(AW'(MEM_DEPTH - 1), b); e = exp_q.pop_front();
        n_checks++; if (b !== e) begin n_fail++; $display("FAIL wrap last: got %h expected %h", b, e); end
        bd_read('0, b); e = exp_q.pop_front();
        n_checks++; if (b !== e) begin n_fail++; $display("FAIL wrap first: got %h expected %h", b, e); end
    endtask

    task automatic test_abort();
        logic [7:0] b, e; logic [3:0] q, oe;
        bd_write(10'h020, 8'h00); bd_write(10'h021, 8'h77);
        cs_begin(); tx_ser(8'h02); tx_addr_ser(24'h000020); tx_ser(8'hA5);
        for (int i = 0; i < 4; i++) pulse(4'h1, q, oe);
        cs_end();
        model[10'h020] = 8'hA5;
        exp_q.push_back(model[10'h020]); exp_q.push_back(model[10'h021]);
        bd_read(10'h020, b); e = exp_q.pop_front();
        n_checks++; if (b !== e) begin n_fail++; $display("FAIL abort byte0: got %h expected %h", b, e); end
        bd_read(10'h021, b); e = exp_q.pop_front();
        n_checks++; if (b !== e) begin n_fail++; $display("FAIL abort byte1: got %h expected %h", b, e); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL abort busy: got %b expected 0", busy); end
        // Abort in the middle of a read byte: the pins must be released.
        cs_begin(); tx_ser(8'h03); tx_addr_ser(24'h000010);
        for (int i = 0; i < 4; i++) pulse(4'h0, q, oe);
        n_checks++; if (oe !== 4'b0010) begin n_fail++; $display("FAIL abort read_oe: got %b expected 0010", oe); end
        #40; ce_n = 1'b1; #60;
        n_checks++; if (sio_oe !== 4'h0) begin n_fail++; $display("FAIL abort oe_release: got %b expected 0", sio_oe); end
        #200;
    endtask

    task automatic test_back_to_back();
        logic [7:0] b, e; logic [3:0] oe;
        bd_write(10'h1FF, 8'h5C);
        cs_begin(); tx_ser(8'h02); tx_addr_ser(24'h000200);
        tx_ser(8'h11); tx_ser(8'h22); tx_ser(8'h33); cs_end();
        model[10'h200] = 8'h11; model[10'h201] = 8'h22; model[10'h202] = 8'h33;
        for (int i = 0; i < 4; i++) exp_q.push_back(model[10'h1FF + i]);
        cs_begin(); tx_ser(8'h03); tx_addr_ser(24'h0001FF);
        for (int i = 0; i < 4; i++) begin
            rx_ser(b, oe); e = exp_q.pop_front();
            n_checks++; if (b !== e) begin n_fail++; $display("FAIL back_to_back byte%0d: got %h expected %h", i, b, e); end
        end
        cs_end();
    endtask

    task automatic test_reset_mid();
        logic [7:0] b, e; logic [3:0] oe; int bad;
        exp_q.push_back(model[10'h010]);
        cs_begin(); tx_ser(8'h03); tx_addr_ser(24'h000010);
        rx_ser(b, oe); e = exp_q.pop_front();
        n_checks++; if (b !== e) begin n_fail++; $display("FAIL reset_mid pre: got %h expected %h", b, e); end
        @(negedge clk); rst = 1'b1; repeat (3) @(negedge clk); rst = 1'b0; @(negedge clk);
        bad = 0;
        for (int i = 0; i < 8; i++) begin dummy(1, oe); if (oe !== 4'h0) bad++; end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL reset_mid rearm: got %0d driven cycles expected 0", bad); end
        cs_end();
        exp_q.push_back(model[10'h011]);
        cs_begin(); tx_ser(8'h03); tx_addr_ser(24'h000011);
        rx_ser(b, oe); e = exp_q.pop_front(); cs_end();
        n_checks++; if (b !== e) begin n_fail++; $display("FAIL reset_mid post: got %h expected %h", b, e); end
    endtask

`ifdef PSRAM_RESP_QPI_EN
    task automatic test_qpi();
        logic [7:0] b, e; logic [3:0] oe;
        cs_begin(); tx_ser(8'h35); cs_end();
        n_checks++; if (qpi_mode !== 1'b1) begin n_fail++; $display("FAIL qpi set: got %b expected 1", qpi_mode); end
        exp_q.push_back(model[10'h100]); exp_q.push_back(model[10'h101]);
        cs_begin(); tx_quad(8'hEB); tx_addr_quad(24'h000100); dummy(6, oe);
        for (int i = 0; i < 2; i++) begin
            rx_quad(b, oe); e = exp_q.pop_front();
            n_checks++; if (b !== e) begin n_fail++; $display("FAIL qpi read byte%0d: got %h expected %h", i, b, e); end
        end
        cs_end();
        cs_begin(); tx_quad(8'hF5); cs_end();
        n_checks++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL qpi clear: got %b expected 0", qpi_mode); end
    endtask
`else
    task automatic test_no_qpi();
        logic [7:0] b, e; logic [3:0] oe; int bad;
        cs_begin(); tx_ser(8'h35); cs_end();
        n_checks++; if (qpi_mode !== 1'b0) begin n_fail++; $display("FAIL no_qpi mode: got %b expected 0", qpi_mode); end
        exp_q.push_back(model[10'h010]);
        cs_begin(); tx_ser(8'h03); tx_addr_ser(24'h000010); rx_ser(b, oe); cs_end();
        e = exp_q.pop_front();
        n_checks++; if (b !== e) begin n_fail++; $display("FAIL no_qpi serial: got %h expected %h", b, e); end
        cs_begin(); tx_ser(8'h9F);
        bad = 0;
        for (int i = 0; i < 20; i++) begin dummy(1, oe); if (oe !== 4'h0) bad++; end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL unknown_cmd oe: got %0d driven cycles expected 0", bad); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL unknown_cmd busy: got %b expected 1", busy); end
        cs_end();
    endtask
`endif

    initial begin
        test_reset();
        test_serial_read();
        test_quad_write_read();
        test_wrap();
        test_abort();
        test_back_to_back();
        test_reset_mid();
`ifdef PSRAM_RESP_QPI_EN
        test_qpi();
`else
        test_no_qpi();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/psram_qspi_responder.md
# psram_qspi_responder

Synthesizable QSPI/QPI PSRAM responder: the device-side counterpart of the EF_PSRAM_CTRL_V2 pins, backed by an on-chip byte array. It oversamples `sck`, `ce_n` and `sio_i` on the system clock, decodes command, address, wait and data phases, and serves reads and writes from its memory. The block stands in for external PSRAM in simulation and FPGA bring-up of the accelerator layers (conv, dense, softmax) that stream activations through the PSRAM controller. A backdoor port preloads weights and inputs and reads back results.

## Interface
- `MEM_DEPTH`, 1024: bytes of backing memory; power of two.
- `ADDR_WIDTH`, 24: serial address bits per transaction.
- `WAIT_CYCLES`, 6: dummy `sck` cycles for command 0xEB.
- `clk` in 1: system clock; must be at least 4x the `sck` frequency.
- `rst` in 1: reset, synchronous, active-high; clock `clk`.
- `sck` in 1: PSRAM serial clock, asynchronous to `clk`.
- `ce_n` in 1: chip enable, active-low.
- `sio_i` in 4: data from the controller (`dout`).
- `sio_o` out 4: data to the controller (`din`).
- `sio_oe` out 4: per-lane output enable.
- `qpi_mode` out 1: 1 when commands are received 4-bit.
- `busy` out 1: 1 while `ce_n` is low (synchronized).
- `bd_en` in 1: backdoor access strobe.
- `bd_we` in 1: backdoor write (1) or read (0).
- `bd_addr` in log2(MEM_DEPTH): backdoor byte address.
- `bd_wdata` in 8: backdoor write data.
- `bd_rdata` out 8: backdoor read data, valid 1 cycle after `bd_en`.

## Operation
- `sck` and `ce_n` pass through 2-flop synchronizers. `sio_i` is delayed to match. Edges are detected on the synchronized signals.
- SPI mode 0 timing:
  - Inputs are sampled on the detected `sck` rise.
  - Outputs update on the detected `sck` fall.
- States:
  - IDLE: waits for `ce_n` fall, then goes to CMD.
  - CMD: collects 8 bits; 1 bit/edge on `sio_i[0]`, or 4 bits/edge when `qpi_mode`=1.
  - ADDR: collects the address; 24 edges serial, 6 edges quad.
  - WAIT: counts WAIT_CYCLES rises.
  - RDATA: drives read data.
  - WDATA: accepts write data.
  - IGNORE: waits for `ce_n` high.
- Commands:
  - 0x03: serial read, no wait, data on `sio_o[1]`.
  - 0x02: serial write.
  - 0xEB: quad address, WAIT, then quad read.
  - 0x38: quad address, then quad write.
  - 0x35 / 0xF5: set / clear `qpi_mode` (see Configuration).
- In `qpi_mode`=1, every address and data phase is quad regardless of the command.
- Any unknown command goes to IGNORE.
- Data order:
  - Serial data is MSB first.
  - Quad data is the high nibble first.
- Memory index is address mod MEM_DEPTH. It increments after each byte and wraps MEM_DEPTH-1 -> 0.
- Write bytes commit in the `clk` cycle after their last bit is sampled. A partial byte at `ce_n` rise is discarded.
- Read: the next byte is fetched when the current byte's last bit or nibble is driven, so read data is continuous.
- A `ce_n` rise in any state forces IDLE, sets `sio_oe`=0 next cycle, and aborts the transaction; `qpi_mode` is retained.
- Backdoor:
  - Legal only while `busy`=0.
  - On a same-cycle write collision, the SPI write wins and the backdoor write is dropped.

## Timing
- Reset values:
  - `sio_o`=0, `sio_oe`=0, `qpi_mode`=0, `busy`=0, `bd_rdata`=0, state IDLE.
  - Memory is not reset.
- Pin to internal edge detect: 3 `clk` cycles.
- `sio_oe`:
  - 4'b0010 in serial RDATA, 4'b1111 in quad RDATA, 0 otherwise.
  - Asserts with the first driven data.
- 0x03 first data: the fall after the 32nd rise drives bit 7 of byte 0.
- 0xEB first data: the fall after the last WAIT rise drives the high nibble of byte 0.
- `rst` mid-transaction: state returns to IDLE. The responder re-arms only on the next `ce_n` fall.

## Configuration
- `PSRAM_RESP_QPI_EN` defined:
  - 0x35 sets `qpi_mode`; 0xF5, received quad, clears it.
  - CMD samples 4 bits/edge while `qpi_mode`=1.
- Undefined:
  - 0x35/0xF5 are unknown commands and go to IGNORE.
  - `qpi_mode` is tied to 0 and CMD is always serial.

## Test plan
- Serial read: backdoor write 0x5A @0x010, 0xC3 @0x011; 0x03, addr 0x000010, 16 data clocks -> `sio_o[1]` bits 01011010 11000011, `sio_oe`=0010.
- Quad write then read:
  - 0x38 @0x000100 with nibbles 1,2,3,4 -> backdoor reads 0x12 @0x100, 0x34 @0x101.
  - 0xEB @0x000100 -> 6 dummy cycles, then nibbles 1,2,3,4 with `sio_oe`=1111.
- Wrap: 0x02 @MEM_DEPTH-1, data 0xAA,0xBB -> memory[MEM_DEPTH-1]=0xAA, memory[0]=0xBB.
- Abort: 0x02 @0x020, `ce_n` raised after 12 data bits -> only byte 0x020 updated, 0x021 unchanged, `busy`=0, `sio_oe`=0.
- QPI (with `PSRAM_RESP_QPI_EN`): 0x35 -> `qpi_mode`=1; quad 0xEB read correct; quad 0xF5 -> `qpi_mode`=0.
- Without the macro: 0x35 -> `qpi_mode` stays 0; unknown 0x9F -> no `sio_oe` until `ce_n` rise.
